// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register indices, exception codes and Status bit positions
// Shared by cp0_exc_ctrl and cp0_timer. No ports.
package cp0_pkg;

    // CP0 register indices (instruction rd field)
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // Exception codes carried on the cause input
    typedef enum logic [4:0] {
        EXC_SYSCALL = 5'b01000,
        EXC_BREAK   = 5'b01001,
        EXC_TEQ     = 5'b01101
    } exc_code_e;

    localparam logic [31:0] EXC_BASE_DEF   = 32'h0000_0004;
    localparam logic [31:0] STATUS_RST_DEF = 32'h0000_000F;

    // Status bit positions: global enable plus one mask per exception code
    localparam int ST_IE_BIT      = 0;
    localparam int ST_SYSCALL_BIT = 1;
    localparam int ST_BREAK_BIT   = 2;
    localparam int ST_TEQ_BIT     = 3;

    // Cause bit owned by the timer match flag
    localparam int          CAUSE_TI_BIT  = 15;
    localparam logic [31:0] CAUSE_TI_MASK = 32'h0000_8000;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - datapath <-> CP0 exception controller bundle
// master: datapath side (drives pc, strobes, addr, wdata, exception, cause, eret)
// slave : CP0 side (drives rdata, status, exc_taken, exc_addr, timer_int)
interface cp0_exc_ctrl_if;
    logic [31:0] pc;
    logic        mfc0;
    logic        mtc0;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        exception;
    logic [4:0]  cause;
    logic        eret;
    logic [31:0] rdata;
    logic [31:0] status;
    logic        exc_taken;
    logic [31:0] exc_addr;
    logic        timer_int;

    modport master (
        output pc, mfc0, mtc0, addr, wdata, exception, cause, eret,
        input  rdata, status, exc_taken, exc_addr, timer_int
    );

    modport slave (
        input  pc, mfc0, mtc0, addr, wdata, exception, cause, eret,
        output rdata, status, exc_taken, exc_addr, timer_int
    );
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - CP0 Count/Compare pair with match flag
// Ports: clk, rst (async active-high); i_wr_en (MTC0 that survived exception/ERET
// priority), i_addr, i_wdata; o_count, o_compare, o_flag (Cause[15] source).
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_flag
);
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_flag;
    logic        w_wr_count;
    logic        w_wr_compare;

    assign w_wr_count   = i_wr_en && (i_addr == REG_COUNT);
    assign w_wr_compare = i_wr_en && (i_addr == REG_COMPARE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_compare <= '0;
            r_flag    <= 1'b0;
        end else begin
            // A load replaces the increment for that cycle
            r_count <= w_wr_count ? i_wdata : r_count + 32'd1;
            if (w_wr_compare) begin
                r_compare <= i_wdata;
            end
            // Writing Compare acknowledges the interrupt; Compare==0 means disarmed
            if (w_wr_compare) begin
                r_flag <= 1'b0;
            end else if ((r_count == r_compare) && (r_compare != '0)) begin
                r_flag <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_flag    = r_flag;
endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception controller: Status/Cause/EPC, MFC0/MTC0, exception/ERET redirect
// Ports: clk, rst (async active-high); bus (cp0_exc_ctrl_if.slave).
// Optional Count/Compare timer under macro CP0_TIMER_EN; without it timer_int is 0
// and indices 9/11 read 0.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_BASE   = EXC_BASE_DEF,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DEF,
    parameter int          SHAMT      = 5
) (
    input  logic           clk,
    input  logic           rst,
    cp0_exc_ctrl_if.slave  bus
);
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;
    logic        w_mask;
    logic        w_exc_taken;
    logic        w_timer_flag;
    logic [31:0] w_cause_view;
    logic [31:0] w_rdata;

    always_comb begin
        w_mask = 1'b0;
        case (bus.cause)
            EXC_SYSCALL: w_mask = r_status[ST_SYSCALL_BIT];
            EXC_BREAK:   w_mask = r_status[ST_BREAK_BIT];
            EXC_TEQ:     w_mask = r_status[ST_TEQ_BIT];
            default:     w_mask = 1'b0;
        endcase
    end

    assign w_exc_taken = bus.exception & r_status[ST_IE_BIT] & w_mask;

`ifdef CP0_TIMER_EN
    logic        w_wr_en;
    logic [31:0] w_count;
    logic [31:0] w_compare;

    // Exception entry and ERET both swallow a concurrent MTC0
    assign w_wr_en = bus.mtc0 & ~w_exc_taken & ~bus.eret;

    cp0_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_addr    (bus.addr),
        .i_wdata   (bus.wdata),
        .o_count   (w_count),
        .o_compare (w_compare),
        .o_flag    (w_timer_flag)
    );
`else
    assign w_timer_flag = 1'b0;
`endif

    // r_cause never holds bit 15; that bit is always the live timer flag
    assign w_cause_view = r_cause | ({31'd0, w_timer_flag} << CAUSE_TI_BIT);

    always_comb begin
        w_rdata = '0;
        if (bus.mfc0) begin
            case (bus.addr)
                REG_STATUS:  w_rdata = r_status;
                REG_CAUSE:   w_rdata = w_cause_view;
                REG_EPC:     w_rdata = r_epc;
`ifdef CP0_TIMER_EN
                REG_COUNT:   w_rdata = w_count;
                REG_COMPARE: w_rdata = w_compare;
`endif
                default:     w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= STATUS_RST;
            r_cause  <= '0;
            r_epc    <= '0;
        end else if (w_exc_taken) begin
            // Shifting left clears IE and the masks, blocking re-entry
            r_epc        <= bus.pc;
            r_cause[6:2] <= bus.cause;
            r_status     <= r_status << SHAMT;
        end else if (bus.eret) begin
            r_status <= r_status >> SHAMT;
        end else if (bus.mtc0) begin
            case (bus.addr)
                REG_STATUS: r_status <= bus.wdata;
                REG_CAUSE:  r_cause  <= bus.wdata & ~CAUSE_TI_MASK;
                REG_EPC:    r_epc    <= bus.wdata;
                default:    ;
            endcase
        end
    end

    assign bus.rdata     = w_rdata;
    assign bus.status    = r_status;
    assign bus.exc_taken = w_exc_taken;
    // ERET wins the redirect mux; on the edge exception entry still wins
    assign bus.exc_addr  = bus.eret ? r_epc : (w_exc_taken ? EXC_BASE : 32'd0);
    assign bus.timer_int = w_timer_flag & r_status[ST_IE_BIT];
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;
    localparam logic [4:0] SYS = 5'b01000;
    localparam logic [4:0] BRK = 5'b01001;
    localparam logic [4:0] TEQ = 5'b01101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   skip_cmp = 1'b0;

    always #5 clk = ~clk;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Architectural model: three named registers updated from the rules
    logic [31:0] m_status, m_cause, m_epc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit accepted(input logic [31:0] st, input logic exc, input logic [4:0] code);
        bit enabled;
        enabled = 1'b0;
        if (code == SYS) enabled = st[1];
        else if (code == BRK) enabled = st[2];
        else if (code == TEQ) enabled = st[3];
        return exc && st[0] && enabled;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_status <= 32'h0000_000F;
            m_cause  <= 32'd0;
            m_epc    <= 32'd0;
        end else if (accepted(m_status, bus.exception, bus.cause)) begin
            m_epc    <= bus.pc;
            m_cause  <= {m_cause[31:7], bus.cause, m_cause[1:0]};
            m_status <= m_status * 32;
        end else if (bus.eret) begin
            m_status <= m_status / 32;
        end else if (bus.mtc0) begin
            if (bus.addr == 5'd12) m_status <= bus.wdata;
            else if (bus.addr == 5'd13) m_cause <= bus.wdata & 32'hFFFF_7FFF;
            else if (bus.addr == 5'd14) m_epc <= bus.wdata;
        end
    end

    // Compare every cycle, mid-period
    always @(negedge clk) begin
        logic [31:0] e_rd, e_addr;
        bit          e_tk;
        if (!rst && !skip_cmp) begin
            e_tk = accepted(m_status, bus.exception, bus.cause);
            e_rd = 32'd0;
            if (bus.mfc0) begin
                if (bus.addr == 5'd12) e_rd = m_status;
                else if (bus.addr == 5'd13) e_rd = m_cause;
                else if (bus.addr == 5'd14) e_rd = m_epc;
            end
            e_addr = bus.eret ? m_epc : (e_tk ? 32'h4 : 32'h0);
            chk("cyc_rdata", bus.rdata, e_rd);
            chk("cyc_status", bus.status, m_status);
            chk("cyc_exc_taken", {31'd0, bus.exc_taken}, {31'd0, e_tk});
            chk("cyc_exc_addr", bus.exc_addr, e_addr);
            chk("cyc_timer_int", {31'd0, bus.timer_int}, 32'd0);
        end
    end

    task automatic idle();
        bus.pc = 32'd0; bus.mfc0 = 1'b0; bus.mtc0 = 1'b0; bus.addr = 5'd0;
        bus.wdata = 32'd0; bus.exception = 1'b0; bus.cause = 5'd0; bus.eret = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input logic [4:0] a, input string nm, input logic [31:0] exp);
        bus.mfc0 = 1'b1; bus.addr = a;
        #1 chk(nm, bus.rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values and unimplemented index
        rd(5'd12, "rst_status_rd", 32'h0000_000F);
        rd(5'd14, "rst_epc_rd", 32'h0);
        rd(5'd5, "unimpl_rd", 32'h0);
        bus.mfc0 = 1'b0; bus.addr = 5'd12;
        #1 chk("mfc0_off_rd", bus.rdata, 32'h0);
        next();

        // SYSCALL entry
        bus.pc = 32'h120; bus.exception = 1'b1; bus.cause = SYS;
        #1 chk("sys_taken", {31'd0, bus.exc_taken}, 32'd1);
        chk("sys_addr", bus.exc_addr, 32'h4);
        next();
        rd(5'd14, "sys_epc", 32'h120);
        rd(5'd13, "sys_cause", 32'h0000_0020);
        chk("sys_status", bus.status, 32'h0000_01E0);
        next();

        // ERET
        bus.eret = 1'b1;
        #1 chk("eret_addr", bus.exc_addr, 32'h120);
        next();
        #1 chk("eret_status", bus.status, 32'h0000_000F);

        // BREAK masked
        bus.mtc0 = 1'b1; bus.addr = 5'd12; bus.wdata = 32'hB;
        next();
        bus.pc = 32'h80; bus.exception = 1'b1; bus.cause = BRK;
        #1 chk("brk_masked_taken", {31'd0, bus.exc_taken}, 32'd0);
        chk("brk_masked_addr", bus.exc_addr, 32'h0);
        next();
        rd(5'd14, "brk_masked_epc", 32'h120);
        next();

        // TEQ with concurrent MTC0 to EPC
        bus.mtc0 = 1'b1; bus.addr = 5'd14; bus.wdata = 32'hDEAD;
        bus.pc = 32'h40; bus.exception = 1'b1; bus.cause = TEQ;
        #1 chk("teq_taken", {31'd0, bus.exc_taken}, 32'd1);
        next();
        rd(5'd14, "teq_epc_wr_dropped", 32'h40);
        chk("teq_status", bus.status, 32'h0000_0160);
        next();

        // Shifted-out Status bits are lost across entry/ERET
        bus.mtc0 = 1'b1; bus.addr = 5'd12; bus.wdata = 32'h8000_000F;
        next();
        bus.pc = 32'h300; bus.exception = 1'b1; bus.cause = SYS;
        #1 chk("hi_taken", {31'd0, bus.exc_taken}, 32'd1);
        next();
        #1 chk("hi_status", bus.status, 32'h0000_01E0);
        bus.exception = 1'b1; bus.cause = SYS; bus.pc = 32'h500;
        #1 chk("nested_masked", {31'd0, bus.exc_taken}, 32'd0);
        next();
        bus.eret = 1'b1;
        #1 chk("hi_eret_addr", bus.exc_addr, 32'h300);
        next();
        #1 chk("hi_restored", bus.status, 32'h0000_000F);

        // Unknown code never taken
        bus.exception = 1'b1; bus.cause = 5'b00001;
        #1 chk("unknown_code", {31'd0, bus.exc_taken}, 32'd0);
        next();

        // Write to unimplemented index ignored
        bus.mtc0 = 1'b1; bus.addr = 5'd5; bus.wdata = 32'h123;
        next();
        rd(5'd5, "unimpl_wr", 32'h0);
        next();

        // No same-cycle bypass
        bus.mtc0 = 1'b1; bus.addr = 5'd14; bus.wdata = 32'h55; bus.mfc0 = 1'b1;
        #1 chk("no_bypass", bus.rdata, 32'h300);
        next();
        rd(5'd14, "wr_visible", 32'h55);
        next();

        // Reset mid-handler
        bus.pc = 32'h200; bus.exception = 1'b1; bus.cause = SYS;
        next();
        #1 chk("pre_rst_status", bus.status, 32'h0000_01E0);
        rst = 1'b1;
        #1 chk("async_rst_status", bus.status, 32'h0000_000F);
        @(posedge clk);
        #1 rst = 1'b0;
        rd(5'd14, "rst_epc_lost", 32'h0);
        bus.mfc0 = 1'b0; bus.eret = 1'b1;
        #1 chk("eret_after_rst", bus.exc_addr, 32'h0);
        next();

`ifdef CP0_TIMER_EN
        begin
            bit hit;
            skip_cmp = 1'b1;
            bus.mtc0 = 1'b1; bus.addr = 5'd9; bus.wdata = 32'd0;
            next();
            bus.mtc0 = 1'b1; bus.addr = 5'd11; bus.wdata = 32'd5;
            next();
            hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                if (bus.timer_int) hit = 1'b1;
                else next();
            end
            chk("timer_int_set", {31'd0, hit}, 32'd1);
            bus.mtc0 = 1'b1; bus.addr = 5'd11; bus.wdata = 32'd100;
            next();
            #1 chk("timer_int_clr", {31'd0, bus.timer_int}, 32'd0);
            next();
            skip_cmp = 1'b0;
        end
`else
        rd(5'd9, "count_absent", 32'h0);
        rd(5'd11, "compare_absent", 32'h0);
        next();
`endif
        repeat (2) next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
